// File: rtl/icx_timing_pkg.sv
// Shared types, default ICX timing constants and window decode for ccd_timing_gen.
package icx_timing_pkg;

  localparam int CW = 12;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    FAST  = 3'd2,
    XFER  = 3'd3,
    LINES = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam int DEF_H_TOTAL     = 1132;
  localparam int DEF_V_TOTAL     = 1052;
  localparam int DEF_INIT_CYCLES = 3340;
  localparam int DEF_FAST_LINES  = 13;
  localparam int DEF_FAST_PERIOD = 352;
  localparam int DEF_V_OFF       = 4;
  localparam int DEF_V_STEP      = 44;
  localparam int DEF_V_WIDTH     = 220;
  localparam logic [3:0] DEF_V_IDLE  = 4'b1001;
  localparam int DEF_SG_START    = 2656;
  localparam int DEF_SG_WIDTH    = 162;
  localparam logic [3:0] DEF_SG_MASK = 4'b0110;
  localparam int DEF_HBLK_END    = 356;
  localparam int DEF_CLPOB_S     = 360;
  localparam int DEF_CLPOB_E     = 386;
  localparam int DEF_SUB_S       = 241;
  localparam int DEF_SUB_E       = 294;
  localparam int XFER_CYCLES     = 8;

  // True when pos lies in the half-open window [lo, lo+len).
  function automatic logic in_window(input logic [CW-1:0] pos,
                                     input logic [31:0] lo,
                                     input logic [31:0] len);
    logic [31:0] p;
    p = 32'(pos);
    return (p >= lo) && (p < lo + len);
  endfunction

endpackage

// File: rtl/ccd_line_counter.sv
// Horizontal/vertical position counter: hpos runs 1..hmax, vpos advances on each wrap.
module ccd_line_counter
  import icx_timing_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          load,
  input  logic          en,
  input  logic [CW-1:0] hmax,
  output logic [CW-1:0] hpos,
  output logic [CW-1:0] vpos,
  output logic          line_end
);

  assign line_end = (hpos == hmax);

  // clr wins over load, load over count enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hpos <= '0;
      vpos <= '0;
    end else if (clr) begin
      hpos <= '0;
      vpos <= '0;
    end else if (load) begin
      hpos <= CW'(1);
      vpos <= '0;
    end else if (en) begin
      if (hpos >= hmax) begin
        hpos <= CW'(1);
        vpos <= vpos + CW'(1);
      end else begin
        hpos <= hpos + CW'(1);
      end
    end
  end

endmodule

// File: rtl/ccd_timing_gen.sv
// Interline CCD frame timing generator (V clocks, SG, HBLANK, CLPOB, SUB shutter).
// Build option: define ICX_SHUTTER_EN to enable the xsub_o shutter and the sub_lines_i latch.
module ccd_timing_gen
  import icx_timing_pkg::*;
#(
  parameter int H_TOTAL     = DEF_H_TOTAL,
  parameter int V_TOTAL     = DEF_V_TOTAL,
  parameter int INIT_CYCLES = DEF_INIT_CYCLES,
  parameter int FAST_LINES  = DEF_FAST_LINES,
  parameter int FAST_PERIOD = DEF_FAST_PERIOD,
  parameter int NPHASE      = 4,
  parameter int V_OFF       = DEF_V_OFF,
  parameter int V_STEP      = DEF_V_STEP,
  parameter int V_WIDTH     = DEF_V_WIDTH,
  parameter logic [NPHASE-1:0] V_IDLE  = NPHASE'(DEF_V_IDLE),
  parameter int SG_START    = DEF_SG_START,
  parameter int SG_WIDTH    = DEF_SG_WIDTH,
  parameter logic [NPHASE-1:0] SG_MASK = NPHASE'(DEF_SG_MASK),
  parameter int HBLK_END    = DEF_HBLK_END,
  parameter int CLPOB_S     = DEF_CLPOB_S,
  parameter int CLPOB_E     = DEF_CLPOB_E,
  parameter int SUB_S       = DEF_SUB_S,
  parameter int SUB_E       = DEF_SUB_E
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic              cont_i,
  input  logic              abort_i,
  input  logic [11:0]       sub_lines_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [NPHASE-1:0] xv_o,
  output logic [NPHASE-1:0] sg_o,
  output logic              hblank_o,
  output logic              clpob_o,
  output logic              xsub_o,
  output logic [11:0]       hpos_o,
  output logic [11:0]       vpos_o,
  output state_t            state_o
);

  generate
    if (H_TOTAL < 1 || H_TOTAL >= 4096 || V_TOTAL < 1 || V_TOTAL >= 4096 ||
        INIT_CYCLES < 1 || INIT_CYCLES >= 4096 || FAST_LINES < 1 || FAST_LINES >= 4096 ||
        FAST_PERIOD < 1 || FAST_PERIOD >= 4096 || V_OFF >= 4096 || V_STEP >= 4096 ||
        V_WIDTH >= 4096 || SG_START >= 4096 || SG_WIDTH >= 4096 || HBLK_END >= 4096 ||
        CLPOB_S >= 4096 || CLPOB_E >= 4096 || SUB_S >= 4096 || SUB_E >= 4096) begin : g_bad_timing
      $error("ccd_timing_gen: timing parameter outside 12-bit counter range");
    end
    if (NPHASE < 2 || NPHASE > 8) begin : g_bad_nphase
      $error("ccd_timing_gen: NPHASE must be 2..8");
    end
  endgenerate

  localparam logic [CW-1:0] INIT_LAST = CW'(INIT_CYCLES - 1);
  localparam logic [CW-1:0] FAST_LAST = CW'(FAST_LINES - 1);
  localparam logic [CW-1:0] FAST_P    = CW'(FAST_PERIOD);
  localparam logic [CW-1:0] H_T       = CW'(H_TOTAL);
  localparam logic [CW-1:0] V_LAST    = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] XFER_LAST = CW'(XFER_CYCLES - 1);
  localparam logic [CW-1:0] HBLK_C    = CW'(HBLK_END);
  localparam logic [CW-1:0] CLP_S_C   = CW'(CLPOB_S);
  localparam logic [CW-1:0] CLP_E_C   = CW'(CLPOB_E);

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          lc_clr, lc_load, lc_en, line_end, frame_start;
  logic [CW-1:0] hpos, vpos, hmax;
  logic [NPHASE-1:0] xv_d, sg_d;
  logic          hblank_d, clpob_d;

  assign hmax    = (state == FAST) ? FAST_P : H_T;
  assign hpos_o  = hpos;
  assign vpos_o  = vpos;
  assign state_o = state;

  ccd_line_counter u_line_counter (
    .clk      (clk),
    .reset    (reset),
    .clr      (lc_clr),
    .load     (lc_load),
    .en       (lc_en),
    .hmax     (hmax),
    .hpos     (hpos),
    .vpos     (vpos),
    .line_end (line_end)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Handshake: start_i is accepted only in IDLE (abort_i has priority); busy_o
  // covers the whole frame and done_o pulses for the single DONE cycle.
  // Readout lines use vpos 0..V_TOTAL-1, so the frame ends after the last hpos of line V_TOTAL-1.
  always_comb begin
    state_nx    = state;
    cnt_nx      = '0;
    lc_clr      = 1'b0;
    lc_load     = 1'b0;
    lc_en       = 1'b0;
    frame_start = 1'b0;
    case (state)
      IDLE: begin
        lc_clr = 1'b1;
        if (start_i) begin
          state_nx    = INIT;
          frame_start = 1'b1;
        end
      end
      INIT: begin
        if (cnt == INIT_LAST) begin
          state_nx = FAST;
          lc_load  = 1'b1;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      FAST: begin
        lc_en = 1'b1;
        if (line_end && vpos == FAST_LAST) begin
          state_nx = XFER;
          lc_clr   = 1'b1;
        end
      end
      XFER: begin
        if (cnt == XFER_LAST) begin
          state_nx = LINES;
          lc_load  = 1'b1;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      LINES: begin
        lc_en = 1'b1;
        if (line_end && vpos == V_LAST) begin
          state_nx = DONE;
          lc_clr   = 1'b1;
        end
      end
      DONE: begin
        if (cont_i) begin
          state_nx    = INIT;
          frame_start = 1'b1;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (abort_i) begin
      state_nx    = IDLE;
      cnt_nx      = '0;
      lc_clr      = 1'b1;
      frame_start = 1'b0;
    end
  end

  always_comb begin
    xv_d     = V_IDLE;
    sg_d     = '0;
    hblank_d = 1'b0;
    clpob_d  = 1'b0;
    case (state)
      INIT: begin
        xv_d = V_IDLE & ~SG_MASK;
        if (in_window(cnt, 32'(SG_START), 32'(SG_WIDTH))) sg_d = SG_MASK;
      end
      FAST, LINES: begin
        for (int k = 0; k < NPHASE; k++) begin
          if (in_window(hpos, 32'(V_OFF + k * V_STEP), 32'(V_WIDTH))) xv_d[k] = ~V_IDLE[k];
        end
        if (state == LINES) begin
          hblank_d = (hpos < HBLK_C);
          clpob_d  = (hpos >= CLP_S_C) && (hpos <= CLP_E_C);
        end
      end
      default: ;
    endcase
    if (abort_i) begin
      xv_d     = V_IDLE;
      sg_d     = '0;
      hblank_d = 1'b0;
      clpob_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      xv_o     <= V_IDLE;
      sg_o     <= '0;
      hblank_o <= 1'b0;
      clpob_o  <= 1'b0;
    end else begin
      busy_o   <= (state_nx != IDLE);
      done_o   <= (state_nx == DONE);
      xv_o     <= xv_d;
      sg_o     <= sg_d;
      hblank_o <= hblank_d;
      clpob_o  <= clpob_d;
    end
  end

`ifdef ICX_SHUTTER_EN
  localparam logic [CW-1:0] V_T     = CW'(V_TOTAL);
  localparam logic [CW-1:0] SUB_S_C = CW'(SUB_S);
  localparam logic [CW-1:0] SUB_E_C = CW'(SUB_E);
  logic [CW-1:0] sub_lines_q;

  // Shutter line count is frozen for the whole frame once it starts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sub_lines_q <= '0;
    end else if (frame_start) begin
      sub_lines_q <= (sub_lines_i >= V_T) ? V_T : sub_lines_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      xsub_o <= 1'b0;
    end else begin
      xsub_o <= (state == LINES) && !abort_i && (vpos < sub_lines_q) &&
                (hpos >= SUB_S_C) && (hpos <= SUB_E_C);
    end
  end
`else
  logic sub_unused;
  assign sub_unused = ^sub_lines_i;
  assign xsub_o     = 1'b0;
`endif

endmodule
